// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// counter width, state encoding and the divide-by-zero quotient.
package md_pkg;

    localparam int          CNT_W     = 4;
    localparam logic [31:0] DIVZERO_Q = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        MD_NOP   = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_if.sv
// EX-stage request/response bundle between the pipeline and the
// multiply/divide unit.
interface md_if;
    logic [3:0]  md_op;
    logic        start;
    logic        cancel;
    logic [31:0] rs_out;
    logic [31:0] rt_out;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] rd_data;

    modport master (
        output md_op, start, cancel, rs_out, rt_out,
        input  busy, hi_out, lo_out, rd_data
    );

    modport slave (
        input  md_op, start, cancel, rs_out, rt_out,
        output busy, hi_out, lo_out, rd_data
    );
endinterface

// File: rtl/md_core.sv
// Combinational 32x32 multiply/divide datapath producing {hi, lo}.
// Signed division works on magnitudes and restores signs afterwards.
module md_core
    import md_pkg::*;
(
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res
);

    logic [63:0] prod_s_s;
    logic [63:0] prod_u_s;
    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;
    logic [31:0] safe_b_s;
    logic [31:0] q_mag_s;
    logic [31:0] r_mag_s;
    logic [31:0] q_sgn_s;
    logic [31:0] r_sgn_s;
    logic [31:0] q_u_s;
    logic [31:0] r_u_s;

    // Sign-extended operands give the correct low 64 bits of a signed product.
    assign prod_s_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u_s = {32'd0, a} * {32'd0, b};

    // Magnitude-based signed divide; 0x80000000 / -1 falls out as 0x80000000 r 0.
    always_comb begin
        abs_a_s  = a[31] ? (32'd0 - a) : a;
        abs_b_s  = b[31] ? (32'd0 - b) : b;
        safe_b_s = (b == 32'd0) ? 32'd1 : b;
        if (abs_b_s == 32'd0) begin
            q_mag_s = 32'd0;
            r_mag_s = 32'd0;
        end else begin
            q_mag_s = abs_a_s / abs_b_s;
            r_mag_s = abs_a_s % abs_b_s;
        end
        q_sgn_s = (a[31] ^ b[31]) ? (32'd0 - q_mag_s) : q_mag_s;
        r_sgn_s = a[31] ? (32'd0 - r_mag_s) : r_mag_s;
        q_u_s   = a / safe_b_s;
        r_u_s   = a % safe_b_s;
    end

    // Result select; divide by zero yields all-ones quotient and dividend remainder.
    always_comb begin
        res = 64'd0;
        case (md_op)
            MD_MULT:  res = prod_s_s;
            MD_MULTU: res = prod_u_s;
            MD_DIV: begin
                if (b == 32'd0) begin
                    res = {a, DIVZERO_Q};
                end else begin
                    res = {r_sgn_s, q_sgn_s};
                end
            end
            MD_DIVU: begin
                if (b == 32'd0) begin
                    res = {a, DIVZERO_Q};
                end else begin
                    res = {r_u_s, q_u_s};
                end
            end
            default:  res = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, runs mult/div for a fixed
// number of cycles with busy raised, and serves mfhi/mflo/mthi/mtlo.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    md_if.slave  bus
);

    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

    md_state_e        state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [31:0]      hi_q,      hi_d;
    logic [31:0]      lo_q,      lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             accept_s;
    logic [63:0]      core_res_s;
    logic [31:0]      rd_data_s;

    md_core u_core (
        .md_op (bus.md_op),
        .a     (bus.rs_out),
        .b     (bus.rt_out),
        .res   (core_res_s)
    );

    // Cancel only gates acceptance; an accepted operation always completes.
    assign accept_s = bus.start & ~bus.cancel & (state_q == ST_IDLE);

    // Next-state: capture result at accept, count down, write HI/LO at count 1.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (is_mul_op(bus.md_op) || is_div_op(bus.md_op)) begin
                        pend_hi_d = core_res_s[63:32];
                        pend_lo_d = core_res_s[31:0];
                        cnt_d     = is_mul_op(bus.md_op) ? MULT_N : DIV_N;
                        state_d   = ST_BUSY;
                    end else if (bus.md_op == MD_MTHI) begin
                        hi_d = bus.rs_out;
                    end else if (bus.md_op == MD_MTLO) begin
                        lo_d = bus.rs_out;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter, pending result and HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    // Read-port mux for mfhi/mflo.
    always_comb begin
        rd_data_s = 32'd0;
        case (bus.md_op)
            MD_MFHI: rd_data_s = hi_q;
            MD_MFLO: rd_data_s = lo_q;
            default: rd_data_s = 32'd0;
        endcase
    end

    assign bus.busy    = (state_q == ST_BUSY);
    assign bus.hi_out  = hi_q;
    assign bus.lo_out  = lo_q;
    assign bus.rd_data = rd_data_s;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit with hand-computed vectors.
module tb_md_unit;
    import md_pkg::*;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    md_if bus ();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one long op, change operands at cycle 2, check busy for n cycles then HI/LO.
    task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        bus.md_op  = op;
        bus.start  = 1'b1;
        bus.cancel = 1'b0;
        bus.rs_out = a;
        bus.rt_out = b;
        step();
        bus.start = 1'b0;
        bus.md_op = MD_NOP;
        for (int i = 0; i < n; i++) begin
            if (i == 2) begin
                bus.rs_out = 32'd1;
                bus.rt_out = 32'd1;
            end
            chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
            step();
        end
        chk({tag, "_done"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_hi"}, bus.hi_out, exp_hi);
        chk({tag, "_lo"}, bus.lo_out, exp_lo);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset      = 1'b1;
        bus.md_op  = MD_NOP;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.rs_out = 32'd0;
        bus.rt_out = 32'd0;
        #3;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_hi", bus.hi_out, 32'd0);
        chk("rst_lo", bus.lo_out, 32'd0);
        chk("rst_rd", bus.rd_data, 32'd0);
        step();
        reset = 1'b0;
        step();

        // mtlo under cancel has no effect, then lands without cancel
        bus.md_op  = MD_MTLO;
        bus.start  = 1'b1;
        bus.cancel = 1'b1;
        bus.rs_out = 32'h1234_5678;
        step();
        chk("mtlo_cancel_lo", bus.lo_out, 32'd0);
        chk("mtlo_cancel_busy", {31'd0, bus.busy}, 32'd0);
        bus.cancel = 1'b0;
        step();
        chk("mtlo_lo", bus.lo_out, 32'h1234_5678);
        chk("mtlo_busy", {31'd0, bus.busy}, 32'd0);
        bus.start = 1'b0;
        bus.md_op = MD_MFLO;
        #1;
        chk("mflo_rd", bus.rd_data, 32'h1234_5678);
        bus.md_op  = MD_MTHI;
        bus.start  = 1'b1;
        bus.rs_out = 32'hCAFE_F00D;
        step();
        bus.start = 1'b0;
        bus.md_op = MD_MFHI;
        #1;
        chk("mfhi_rd", bus.rd_data, 32'hCAFE_F00D);
        bus.md_op = MD_NOP;
        #1;
        chk("nop_rd", bus.rd_data, 32'd0);

        run_md("mult",  MD_MULT,  32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_md("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);

        // undefined op behaves as NOP
        bus.md_op  = 4'hF;
        bus.start  = 1'b1;
        bus.rs_out = 32'h5555_AAAA;
        step();
        bus.start = 1'b0;
        chk("undef_busy", {31'd0, bus.busy}, 32'd0);
        chk("undef_hi", bus.hi_out, 32'h0000_0001);
        chk("undef_lo", bus.lo_out, 32'hFFFF_FFFE);
        chk("undef_rd", bus.rd_data, 32'd0);

        run_md("div_neg",  MD_DIV,  32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("div_ovf",  MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,        32'h8000_0000);
        run_md("div_pn",   MD_DIV,  32'd7,        32'hFFFF_FFFE, 10, 32'd1,        32'hFFFF_FFFD);
        run_md("div_z",    MD_DIV,  32'hFFFF_FFFB, 32'd0,        10, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_md("divu_z",   MD_DIVU, 32'd7,        32'd0,        10, 32'd7,        32'hFFFF_FFFF);
        run_md("divu_big", MD_DIVU, 32'hFFFF_FFFF, 32'd2,        10, 32'd1,        32'h7FFF_FFFF);

        // start while busy is ignored; the held MULT is taken right after
        bus.md_op  = MD_DIV;
        bus.start  = 1'b1;
        bus.rs_out = 32'd100;
        bus.rt_out = 32'd7;
        step();
        bus.md_op  = MD_MULT;
        bus.rs_out = 32'd3;
        bus.rt_out = 32'd4;
        for (int i = 0; i < 10; i++) begin
            chk("hold_busy", {31'd0, bus.busy}, 32'd1);
            step();
        end
        chk("hold_div_busy", {31'd0, bus.busy}, 32'd0);
        chk("hold_div_hi", bus.hi_out, 32'd2);
        chk("hold_div_lo", bus.lo_out, 32'd14);
        step();
        bus.start = 1'b0;
        bus.md_op = MD_NOP;
        chk("reissue_busy", {31'd0, bus.busy}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("reissue_hold", {31'd0, bus.busy}, 32'd1);
        end
        step();
        chk("reissue_done", {31'd0, bus.busy}, 32'd0);
        chk("reissue_hi", bus.hi_out, 32'd0);
        chk("reissue_lo", bus.lo_out, 32'd12);

        // asynchronous reset in the middle of a divide
        bus.md_op  = MD_DIV;
        bus.start  = 1'b1;
        bus.rs_out = 32'd9;
        bus.rt_out = 32'd2;
        step();
        bus.start = 1'b0;
        bus.md_op = MD_NOP;
        step();
        step();
        step();
        chk("mid_busy", {31'd0, bus.busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_hi", bus.hi_out, 32'd0);
        chk("arst_lo", bus.lo_out, 32'd0);
        step();
        reset = 1'b0;
        repeat (12) step();
        chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("post_rst_hi", bus.hi_out, 32'd0);
        chk("post_rst_lo", bus.lo_out, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the EX stage, alongside the ALU; consumes the same forwarded rs/rt operands.
- Executes mult/multu/div/divu over a fixed number of cycles and owns the HI/LO registers.
- Serves mfhi/mflo/mthi/mtlo.
- Exports busy to the hazard unit for stalling; honours an exception/interrupt cancel from the P7 CP0 path.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- md_op  in  4  operation code (encodings in md_pkg)
- start  in  1  EX-stage instruction holds a valid md_op this cycle
- cancel  in  1  EX-stage instruction is being flushed by an exception/interrupt
- rs_out  in  32  operand A (forwarded rs)
- rt_out  in  32  operand B (forwarded rt)
- busy  out  1  operation in flight
- hi_out  out  32  current HI
- lo_out  out  32  current LO
- rd_data  out  32  mfhi → hi_out, mflo → lo_out, otherwise 0 (combinational)

Behaviour:
- Reset (asynchronous, active-high, any time including mid-operation): hi=0, lo=0, busy=0, counter=0, pending result cleared, no later write-back.
- Accept condition: start & ~cancel & ~busy.
  - start while busy: ignored (the hazard unit stalls).
  - start with cancel=1: no effect of any kind.
- Ops: NOP(0), MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
  - Undefined codes behave as NOP.
- MTHI/MTLO: on an accepted edge, hi (resp. lo) ← rs_out. Immediate write, busy stays 0.
- MFHI/MFLO: no state change. rd_data is combinational from the current registers.
- MULT/MULTU/DIV/DIVU on an accepted edge E0:
  - Compute the 64-bit result from rs_out/rt_out and capture it into pending_hi/pending_lo.
  - Operands may change afterwards without effect.
  - Load counter with N (MULT_CYCLES or DIV_CYCLES); busy ← 1.
- Each later edge decrements the counter. At the edge where counter==1: hi ← pending_hi, lo ← pending_lo, busy ← 0, counter ← 0.
  - busy is therefore high for exactly N cycles.
  - The next op may be accepted on the cycle busy is 0.
- Once accepted, an operation is not cancelled; cancel only gates acceptance (MIPS semantics).
- MULT: signed 32×32 → 64; hi = [63:32], lo = [31:0]. MULTU: unsigned.
- DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (both div and divu): lo = 0xFFFFFFFF, hi = dividend.
- MTHI/MTLO during busy are never accepted, so HI/LO have only one writer per cycle.

Decomposition:
- md_pkg: md_op encodings (MD_NOP..MD_MTLO), counter width (4), DIVZERO_Q constant 0xFFFFFFFF.
- One sub-module, md_core: combinational; inputs md_op, a, b; output 64-bit {hi,lo}.
  - Covers signed/unsigned multiply, divide, and the divide-by-zero and overflow rules.
- md_unit holds the counter, busy, the pending registers, HI/LO and the rd_data mux.

Test Plan:
- Reset mid-divide: DIV started, reset asserted at cycle 4 → busy=0 and hi=lo=0 immediately (asynchronous); no write-back ever follows.
- MULT rs=0xFFFFFFFF (−1), rt=2 → busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU rs=7, rt=0 → lo=0xFFFFFFFF, hi=7. Operands changed to 1/1 at cycle 2 → the result is unchanged.
- MTLO rs=0x12345678 with cancel=1 → lo unchanged. Repeat with cancel=0 → lo=0x12345678 next edge, busy stays 0. MFLO → rd_data=0x12345678.
- start=1 with MULT while busy from a prior DIV → ignored; the DIV result lands at cycle 10 and busy drops. The re-issued MULT is accepted the following cycle.
